// File: rtl/ux_upscale_sat_p2.sv
// ---------------------------------------------------------------------------
// ux_upscale_sat_p2
//
// Widens a narrow signed sample into a wider signed datapath word by a
// runtime left shift (y = x * 2^sh). The result is sign-extended and then
// saturated to the output range. Two pipeline stages sit behind a
// valid/ready handshake. Saturation is reported three ways: per sample
// (y_sat), as a sticky flag, and as a count that stops at its maximum.
//
// Ports
//   CLK         clock; all state changes on the rising edge
//   RESET       synchronous, active-high reset
//   CE          clock enable; when low all state holds and in_ready is 0
//   in_valid    x/sh are valid this cycle
//   in_ready    block accepts x/sh this cycle
//   x           signed input sample, InLength bits
//   sh          unsigned left-shift amount, sampled together with x
//   out_valid   y/y_sat are valid
//   out_ready   downstream accepts y this cycle
//   y           signed saturated result, OutLength bits
//   y_sat       this y was saturated (qualified by out_valid)
//   sat_sticky  set by any saturated transfer; cleared by sat_clr
//   sat_count   saturated transfers accepted downstream; stops at all-ones
//   sat_clr     clears sat_sticky and sat_count; wins over a same-cycle count
// ---------------------------------------------------------------------------
module ux_upscale_sat_p2 #(
  parameter int InLength   = 16,
  parameter int OutLength  = 24,
  parameter int ShiftWidth = 4,
  parameter int CountWidth = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [InLength-1:0]   x,
  input  logic [ShiftWidth-1:0] sh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OutLength-1:0]  y,
  output logic                  y_sat,
  output logic                  sat_sticky,
  output logic [CountWidth-1:0] sat_count,
  input  logic                  sat_clr
);

  // The shifted product is wide enough that no shift amount loses bits.
  // Overflow detection therefore only needs to look at the bits above the
  // output sign bit.
  localparam int ProdWidth  = InLength + (1 << ShiftWidth) - 1;
  localparam int UpperWidth = ProdWidth - OutLength + 1;

  localparam logic [OutLength-1:0]  SatMax   = {1'b0, {(OutLength-1){1'b1}}};
  localparam logic [OutLength-1:0]  SatMin   = {1'b1, {(OutLength-1){1'b0}}};
  localparam logic [CountWidth-1:0] CountMax = {CountWidth{1'b1}};
  localparam logic [CountWidth-1:0] CountOne = {{(CountWidth-1){1'b0}}, 1'b1};

  logic                  adv;
  logic                  accept;
  logic                  xfer;
  logic [ProdWidth-1:0]  x_ext;
  logic [ProdWidth-1:0]  prod;
  logic [UpperWidth-1:0] prod_upper;
  logic                  ovf_hi;
  logic                  ovf_lo;

  logic                  s1_valid_q, s1_valid_d;
  logic [OutLength-1:0]  s1_low_q,   s1_low_d;
  logic                  s1_hi_q,    s1_hi_d;
  logic                  s1_lo_q,    s1_lo_d;
  logic                  out_valid_q, out_valid_d;
  logic [OutLength-1:0]  y_q,        y_d;
  logic                  y_sat_q,    y_sat_d;
  logic                  sat_sticky_q, sat_sticky_d;
  logic [CountWidth-1:0] sat_count_q,  sat_count_d;

  // Handshake. The pipeline moves as a whole whenever the output register is
  // empty or being drained, so a stall at the output freezes both stages.
  // A transfer also needs CE, otherwise the frozen output would be counted
  // again on the following enabled cycle.
  always_comb begin
    adv      = CE & (~out_valid_q | out_ready);
    in_ready = adv & ~RESET;
    accept   = in_valid & in_ready;
    xfer     = CE & out_valid_q & out_ready;
  end

  // Sign-extend, shift, and classify the product. The result overflows
  // high when it is positive and any upper bit is set, and overflows low
  // when it is negative and any upper bit is clear. Exactly hitting the most
  // negative output value keeps every upper bit set, so it is not
  // saturation.
  always_comb begin
    x_ext      = {{(ProdWidth-InLength){x[InLength-1]}}, x};
    prod       = x_ext << sh;
    prod_upper = prod[ProdWidth-1:OutLength-1];
    ovf_hi     = ~prod[ProdWidth-1] & (|prod_upper);
    ovf_lo     = prod[ProdWidth-1] & ~(&prod_upper);
  end

  // Next-state for both pipeline stages. Stage-1 data only loads on an
  // accepted sample, so bubbles leave the last real value in place and y
  // stays deterministic even though it is reloaded on every advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_low_d    = s1_low_q;
    s1_hi_d     = s1_hi_q;
    s1_lo_d     = s1_lo_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    y_sat_d     = y_sat_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_low_d = prod[OutLength-1:0];
        s1_hi_d  = ovf_hi;
        s1_lo_d  = ovf_lo;
      end
      out_valid_d = s1_valid_q;
      if (s1_hi_q) begin
        y_d = SatMax;
      end else if (s1_lo_q) begin
        y_d = SatMin;
      end else begin
        y_d = s1_low_q;
      end
      y_sat_d = s1_hi_q | s1_lo_q;
    end
  end

  // Saturation accounting. A clear wins over a same-cycle saturated
  // transfer. The counter stops at all-ones instead of wrapping, and
  // nothing here changes while CE is low.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_count_d  = sat_count_q;
    if (CE) begin
      if (sat_clr) begin
        sat_sticky_d = 1'b0;
        sat_count_d  = '0;
      end else if (xfer && y_sat_q) begin
        sat_sticky_d = 1'b1;
        if (sat_count_q != CountMax) begin
          sat_count_d = sat_count_q + CountOne;
        end
      end
    end
  end

  // State registers with synchronous reset. Reset drops anything that is
  // in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q   <= 1'b0;
      s1_low_q     <= '0;
      s1_hi_q      <= 1'b0;
      s1_lo_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      y_q          <= '0;
      y_sat_q      <= 1'b0;
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_low_q     <= s1_low_d;
      s1_hi_q      <= s1_hi_d;
      s1_lo_q      <= s1_lo_d;
      out_valid_q  <= out_valid_d;
      y_q          <= y_d;
      y_sat_q      <= y_sat_d;
      sat_sticky_q <= sat_sticky_d;
      sat_count_q  <= sat_count_d;
    end
  end

  // Drive the output ports from the registers.
  always_comb begin
    out_valid  = out_valid_q;
    y          = y_q;
    y_sat      = y_sat_q;
    sat_sticky = sat_sticky_q;
    sat_count  = sat_count_q;
  end

endmodule

// File: tb/tb_ux_upscale_sat_p2.sv
// ---------------------------------------------------------------------------
// tb_ux_upscale_sat_p2
//
// Directed testbench for ux_upscale_sat_p2 (16-bit in, 24-bit out, 4-bit
// shift, 16-bit counter). Each task drives one scenario and compares the
// outputs against hand-computed values inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ux_upscale_sat_p2;

  logic        CLK;
  logic        RESET;
  logic        CE;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [3:0]  sh;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] y;
  logic        y_sat;
  logic        sat_sticky;
  logic [15:0] sat_count;
  logic        sat_clr;

  int          n_cmp;
  int          n_fail;
  logic [15:0] exp_count;
  logic        exp_sticky;

  ux_upscale_sat_p2 #(
    .InLength(16), .OutLength(24), .ShiftWidth(4), .CountWidth(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .sh(sh),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_sat(y_sat),
    .sat_sticky(sat_sticky), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time limit so the run always ends even if the design wedges.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock, then settle just past the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Push one sample through an idle pipeline with out_ready high and check
  // latency, result and the saturation accounting after the transfer.
  task automatic send_one(input logic [15:0] xi, input logic [3:0] si,
                          input logic [23:0] ey, input logic es,
                          input string name);
    x = xi; sh = si; in_valid = 1'b1; out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL %s in_ready: got %b expected 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL %s early out_valid: got %b expected 0", name, out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL %s out_valid: got %b expected 1", name, out_valid);
    end
    n_cmp++;
    if (y !== ey) begin
      n_fail++; $display("[TB] FAIL %s y: got %h expected %h", name, y, ey);
    end
    n_cmp++;
    if (y_sat !== es) begin
      n_fail++; $display("[TB] FAIL %s y_sat: got %b expected %b", name, y_sat, es);
    end
    step();
    if (es) begin
      exp_sticky = 1'b1;
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    end
    n_cmp++;
    if (sat_count !== exp_count) begin
      n_fail++; $display("[TB] FAIL %s sat_count: got %h expected %h", name, sat_count, exp_count);
    end
    n_cmp++;
    if (sat_sticky !== exp_sticky) begin
      n_fail++; $display("[TB] FAIL %s sat_sticky: got %b expected %b", name, sat_sticky, exp_sticky);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL %s drained out_valid: got %b expected 0", name, out_valid);
    end
  endtask

  // Reset values, and in_ready low while RESET is high.
  task automatic test_reset();
    RESET = 1'b1; CE = 1'b1; in_valid = 1'b0; x = '0; sh = '0;
    out_ready = 1'b0; sat_clr = 1'b0;
    step(); step();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset in_ready: got %b expected 0", in_ready);
    end
    n_cmp++;
    if ({out_valid, y_sat, sat_sticky} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset flags: got %b expected 000", {out_valid, y_sat, sat_sticky});
    end
    n_cmp++;
    if (y !== 24'h0) begin
      n_fail++; $display("[TB] FAIL reset y: got %h expected 000000", y);
    end
    n_cmp++;
    if (sat_count !== 16'h0) begin
      n_fail++; $display("[TB] FAIL reset sat_count: got %h expected 0000", sat_count);
    end
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL post-reset in_ready: got %b expected 1", in_ready);
    end
    exp_count = '0; exp_sticky = 1'b0;
  endtask

  // Basic shift with two-cycle latency.
  task automatic test_latency();
    send_one(16'h1234, 4'd4, 24'h012340, 1'b0, "latency");
  endtask

  // Saturation boundaries at both ends plus a few non-saturating shifts.
  task automatic test_saturation();
    send_one(16'h7FFF, 4'd8,  24'h7FFF00, 1'b0, "pos_edge_ok");
    send_one(16'h7FFF, 4'd9,  24'h7FFFFF, 1'b1, "pos_sat");
    send_one(16'h8000, 4'd8,  24'h800000, 1'b0, "neg_exact_min");
    send_one(16'h8000, 4'd9,  24'h800000, 1'b1, "neg_sat");
    send_one(16'h8000, 4'd0,  24'hFF8000, 1'b0, "sh0_neg");
    send_one(16'h1234, 4'd0,  24'h001234, 1'b0, "sh0_pos");
    send_one(16'h0001, 4'd15, 24'h008000, 1'b0, "one_sh15");
    send_one(16'hFFFF, 4'd15, 24'hFF8000, 1'b0, "m1_sh15");
  endtask

  // Stream 1..8 with sh=1 and out_ready low in cycles 3..7.
  task automatic test_back_to_back();
    int          sent;
    int          recv;
    logic        stalled_prev;
    logic [23:0] held;
    sent = 0; recv = 0; stalled_prev = 1'b0; held = '0;
    sh = 4'd1;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      in_valid  = (sent < 8);
      x         = 16'(sent + 1);
      out_ready = !(c >= 3 && c <= 7);
      @(negedge CLK);
      if (stalled_prev) begin
        n_cmp++;
        if (y !== held) begin
          n_fail++; $display("[TB] FAIL stall hold y: got %h expected %h", y, held);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("[TB] FAIL stall in_ready: got %b expected 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (y !== 24'((recv + 1) * 2)) begin
          n_fail++; $display("[TB] FAIL stream y[%0d]: got %h expected %h", recv, y, 24'((recv + 1) * 2));
        end
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      held = y;
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (recv != 8) begin
      n_fail++; $display("[TB] FAIL stream count: got %0d expected 8", recv);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stream duplicate: got out_valid %b expected 0", out_valid);
    end
  endtask

  // CE low freezes everything including the counter and ignores sat_clr.
  task automatic test_ce_freeze();
    int          sent;
    int          recv;
    logic        prev_ce;
    logic        prev_ov;
    logic [23:0] prev_y;
    send_one(16'h7FFF, 4'd15, 24'h7FFFFF, 1'b1, "ce_pre");
    CE = 1'b0; sat_clr = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ce in_ready: got %b expected 0", in_ready);
    end
    n_cmp++;
    if (sat_count !== exp_count || sat_sticky !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ce clr ignored: got %h/%b expected %h/1", sat_count, sat_sticky, exp_count);
    end
    sat_clr = 1'b0; CE = 1'b1;
    sent = 0; recv = 0; prev_ce = 1'b1; prev_ov = 1'b0; prev_y = '0;
    sh = 4'd2; out_ready = 1'b1;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      CE       = !(c >= 3 && c <= 6);
      in_valid = (sent < 6);
      x        = 16'(10 + sent);
      @(negedge CLK);
      if (!prev_ce) begin
        n_cmp++;
        if (y !== prev_y || out_valid !== prev_ov) begin
          n_fail++; $display("[TB] FAIL ce frozen: got %h/%b expected %h/%b", y, out_valid, prev_y, prev_ov);
        end
      end
      if (!CE) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("[TB] FAIL ce stream in_ready: got %b expected 0", in_ready);
        end
      end
      if (CE && out_valid && out_ready) begin
        n_cmp++;
        if (y !== 24'((10 + recv) * 4)) begin
          n_fail++; $display("[TB] FAIL ce y[%0d]: got %h expected %h", recv, y, 24'((10 + recv) * 4));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_ce = CE; prev_ov = out_valid; prev_y = y;
      step();
    end
    CE = 1'b1; in_valid = 1'b0;
    n_cmp++;
    if (recv != 6) begin
      n_fail++; $display("[TB] FAIL ce count: got %0d expected 6", recv);
    end
    n_cmp++;
    if (sat_count !== exp_count) begin
      n_fail++; $display("[TB] FAIL ce sat_count: got %h expected %h", sat_count, exp_count);
    end
  endtask

  // Reset with two samples in flight drops both.
  task automatic test_reset_mid();
    out_ready = 1'b1; sh = 4'd0;
    x = 16'h0005; in_valid = 1'b1;
    step();
    x = 16'h0006;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || y !== 24'h000005) begin
      n_fail++; $display("[TB] FAIL rstmid pre: got %b/%h expected 1/000005", out_valid, y);
    end
    in_valid = 1'b0; RESET = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid in_ready: got %b expected 0", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || y !== 24'h0) begin
      n_fail++; $display("[TB] FAIL rstmid out: got %b/%h expected 0/000000", out_valid, y);
    end
    RESET = 1'b0;
    exp_count = '0; exp_sticky = 1'b0;
    step(); step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid dropped: got out_valid %b expected 0", out_valid);
    end
    n_cmp++;
    if (sat_count !== 16'h0 || sat_sticky !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid sat: got %h/%b expected 0000/0", sat_count, sat_sticky);
    end
  endtask

  // Counter stops at 0xFFFF, and sat_clr beats a concurrent saturated transfer.
  task automatic test_sat_counter();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_count !== 16'h0 || sat_sticky !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr: got %h/%b expected 0000/0", sat_count, sat_sticky);
    end
    x = 16'h7FFF; sh = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65545) step();
    in_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (sat_count !== 16'hFFFF || sat_sticky !== 1'b1) begin
      n_fail++; $display("[TB] FAIL count hold: got %h/%b expected FFFF/1", sat_count, sat_sticky);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || y_sat !== 1'b1) begin
      n_fail++; $display("[TB] FAIL clr-race setup: got %b/%b expected 1/1", out_valid, y_sat);
    end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    n_cmp++;
    if (sat_count !== 16'h0 || sat_sticky !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr priority: got %h/%b expected 0000/0", sat_count, sat_sticky);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_latency();
    test_saturation();
    test_back_to_back();
    test_ce_freeze();
    test_reset_mid();
    test_sat_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
